// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, registered flush and redirect PC.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

    state_t      state;
    logic [31:0] exc_lat;
    logic [31:0] epc_lat;
    logic        exc_present;

    function automatic logic [31:0] redirect_target(input logic [31:0] code,
                                                    input logic [31:0] epc);
        return (code == ERET_CODE) ? epc : EXC_VECTOR;
    endfunction

    assign exc_present = (excepttype_i != 32'h0);

    always_comb begin
        stall = 6'b000000;
        if (rst) begin
            case (state)
                RUN: begin
                    if (exc_present || stallreq_mem_i) stall = 6'b011111;
                    else if (stallreq_ex_i)            stall = 6'b001111;
                    else if (stallreq_id_i)            stall = 6'b000111;
                    else if (stallreq_if_i)            stall = 6'b000011;
                end
                PEND:    stall = 6'b011111;
                default: stall = 6'b000000;
            endcase
        end
    end

    // Redirect is committed one cycle before flush is visible, so flush and new_pc are clean flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            flush   <= 1'b0;
            new_pc  <= 32'h0;
            exc_lat <= 32'h0;
            epc_lat <= 32'h0;
        end else begin
            flush <= 1'b0;
            case (state)
                RUN: begin
                    if (exc_present) begin
                        if (stallreq_mem_i) begin
                            exc_lat <= excepttype_i;
                            epc_lat <= epc_i;
                            state   <= PEND;
                        end else begin
                            new_pc <= redirect_target(excepttype_i, epc_i);
                            flush  <= 1'b1;
                            state  <= FLUSH;
                        end
                    end
                end
                PEND: begin
                    if (!stallreq_mem_i) begin
                        new_pc <= redirect_target(exc_lat, epc_lat);
                        flush  <= 1'b1;
                        state  <= FLUSH;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 32'h0;
            flush_cnt <= 16'h0;
        end else begin
            if (stall[0]) stall_cnt <= sat_inc32(stall_cnt);
            if (flush)    flush_cnt <= sat_inc16(flush_cnt);
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: stall priority, exception/ERET redirect, PEND hold, reset abort, counters.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if_i = 1'b0;
    logic        stallreq_id_i = 1'b0;
    logic        stallreq_ex_i = 1'b0;
    logic        stallreq_mem_i = 1'b0;
    logic [31:0] excepttype_i = 32'h0;
    logic [31:0] epc_i = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int compared = 0;
    int mismatched = 0;
    int exp_sc = 0;
    int exp_fc = 0;

    pipe_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if_i (stallreq_if_i),
        .stallreq_id_i (stallreq_id_i),
        .stallreq_ex_i (stallreq_ex_i),
        .stallreq_mem_i(stallreq_mem_i),
        .excepttype_i  (excepttype_i),
        .epc_i         (epc_i),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check at the falling edge, then advance past the rising edge.
    task automatic cyc(input string tag, input logic [3:0] req, input logic [31:0] exc,
                       input logic [31:0] epc, input logic [5:0] e_stall,
                       input logic e_flush, input logic [31:0] e_pc);
        {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = req;
        excepttype_i = exc;
        epc_i        = epc;
        @(negedge clk);
        chk({tag, ".stall"}, {26'h0, stall}, {26'h0, e_stall});
        chk({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
        chk({tag, ".new_pc"}, new_pc, e_pc);
        if (e_stall[0]) exp_sc++;
        if (e_flush)    exp_fc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef PIPE_CTRL_PERF_EN
        chk({tag, ".stall_cnt"}, stall_cnt_o, exp_sc);
        chk({tag, ".flush_cnt"}, {16'h0, flush_cnt_o}, exp_fc);
`else
        chk({tag, ".stall_cnt"}, stall_cnt_o, 32'h0);
        chk({tag, ".flush_cnt"}, {16'h0, flush_cnt_o}, 32'h0);
`endif
    endtask

    initial begin
        // Reset with noisy inputs: everything must read zero.
        stallreq_mem_i = 1'b1;
        stallreq_ex_i  = 1'b1;
        excepttype_i   = 32'h8;
        #1 rst = 1'b0;
        #1;
        chk("rst.stall", {26'h0, stall}, 32'h0);
        chk("rst.flush", {31'h0, flush}, 32'h0);
        chk("rst.new_pc", new_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.stall", {26'h0, stall}, 32'h0);
        chk_cnt("rst");
        rst = 1'b0;
        {stallreq_mem_i, stallreq_ex_i} = 2'b00;
        excepttype_i = 32'h0;
        rst = 1'b1;

        // Stall priority in RUN: {mem,ex,id,if}
        cyc("idle",   4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
        cyc("if",     4'b0001, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0);
        cyc("id",     4'b0010, 32'h0, 32'h0, 6'b000111, 1'b0, 32'h0);
        cyc("ex",     4'b0100, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0);
        cyc("mem",    4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        cyc("id_ex",  4'b0110, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0);
        cyc("all",    4'b1111, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0);
        cyc("none",   4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);

        // Plain exception -> vector
        cyc("exc.det", 4'b0000, 32'h8, 32'h0, 6'b011111, 1'b0, 32'h0);
        cyc("exc.fl",  4'b0000, 32'h0, 32'h0, 6'b000000, 1'b1, 32'h20);
        cyc("exc.aft", 4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h20);

        // ERET -> epc; stall requests ignored during flush; back-to-back exception
        cyc("eret.det", 4'b0000, 32'he, 32'h1234, 6'b011111, 1'b0, 32'h20);
        cyc("eret.fl",  4'b0110, 32'h0, 32'h0,    6'b000000, 1'b1, 32'h1234);
        cyc("b2b.det",  4'b0000, 32'h8, 32'h0,    6'b011111, 1'b0, 32'h1234);
        cyc("b2b.fl",   4'b0000, 32'h0, 32'h0,    6'b000000, 1'b1, 32'h20);
        cyc("b2b.aft",  4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h20);

        // Exception under mem stall: code change during PEND is ignored
        cyc("pend.det", 4'b1000, 32'h8, 32'h5555, 6'b011111, 1'b0, 32'h20);
        cyc("pend.1",   4'b1000, 32'he, 32'h7777, 6'b011111, 1'b0, 32'h20);
        cyc("pend.2",   4'b1000, 32'he, 32'h7777, 6'b011111, 1'b0, 32'h20);
        cyc("pend.rel", 4'b0000, 32'h0, 32'h0,    6'b011111, 1'b0, 32'h20);
        cyc("pend.fl",  4'b0000, 32'h0, 32'h0,    6'b000000, 1'b1, 32'h20);
        cyc("pend.aft", 4'b0000, 32'h0, 32'h0,    6'b000000, 1'b0, 32'h20);
        chk_cnt("mid");

        // Reset during PEND aborts the redirect
        cyc("abort.det", 4'b1000, 32'h8, 32'h0, 6'b011111, 1'b0, 32'h20);
        rst = 1'b0;
        #1;
        chk("abort.flush", {31'h0, flush}, 32'h0);
        chk("abort.new_pc", new_pc, 32'h0);
        @(negedge clk);
        chk("abort.stall", {26'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        exp_sc = 0;
        exp_fc = 0;
        chk_cnt("abort");
        stallreq_mem_i = 1'b0;
        excepttype_i   = 32'h0;
        rst = 1'b1;
        cyc("post.0", 4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
        cyc("post.1", 4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);
        cyc("post.2", 4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0);

        // Counter scenario: 5 stall cycles and 2 flushes
        for (int i = 0; i < 5; i++)
            cyc("cnt.st", 4'b0001, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0);
        cyc("cnt.d1", 4'b0000, 32'h8, 32'h0,  6'b011111, 1'b0, 32'h0);
        cyc("cnt.f1", 4'b0000, 32'h0, 32'h0,  6'b000000, 1'b1, 32'h20);
        cyc("cnt.d2", 4'b0000, 32'he, 32'h40, 6'b011111, 1'b0, 32'h20);
        cyc("cnt.f2", 4'b0000, 32'h0, 32'h0,  6'b000000, 1'b1, 32'h40);
        cyc("cnt.end", 4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h40);
        chk_cnt("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, 32'h0000_0020, PC loaded on any non-ERET exception.
REQ-002 Parameter ERET_CODE, 32'h0000_000e, excepttype value meaning return-from-exception.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i  input  1 each  stall requests from IF/ID/EX/MEM.
REQ-006 excepttype_i  input  32  exception code from MEM stage; non-zero = exception present.
REQ-007 epc_i  input  32  return address for ERET.
REQ-008 stall  output  6  per-stage hold: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB.
REQ-009 flush  output  1  registered, one-cycle pipeline flush.
REQ-010 new_pc  output  32  registered redirect target, valid while flush=1.
REQ-011 stall_cnt_o  output  32  stalled-cycle count; flush_cnt_o  output  16  flush count.

Function
REQ-012 FSM states RUN, PEND, FLUSH; stall is combinational from state and requests; flush/new_pc are registered.
REQ-013 RUN, excepttype_i=0: stall = 6'b011111 if mem req, else 6'b001111 if ex, else 6'b000111 if id, else 6'b000011 if if-req, else 6'b000000; highest stage wins on simultaneous requests.
REQ-014 RUN, excepttype_i!=0, stallreq_mem_i=0 (detect cycle): stall=6'b011111; latch target (epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR); next state FLUSH.
REQ-015 RUN, excepttype_i!=0, stallreq_mem_i=1: latch excepttype_i and epc_i, stall=6'b011111, next state PEND.
REQ-016 PEND: excepttype_i ignored; stall=6'b011111; when stallreq_mem_i=0, target computed from the latched values, next state FLUSH.
REQ-017 FLUSH: flush=1, new_pc=target, stall=6'b000000 for exactly one cycle; next state RUN.
REQ-018 flush=0 in every other cycle; new_pc holds its last value when flush=0.
REQ-019 Exception in the cycle right after FLUSH is handled as a new event (back-to-back flushes legal, minimum 2 cycles apart).
REQ-020 Stall requests in FLUSH cycle are ignored (pipeline is being emptied).

Reset
REQ-021 rst=0 asynchronously forces: state=RUN, flush=0, new_pc=32'h0, latched code/epc=0, counters=0.
REQ-022 While rst=0, stall=6'b000000 regardless of inputs.
REQ-023 Reset asserted in PEND or FLUSH aborts the pending redirect; no flush after release.

Configuration
REQ-024 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o increments each cycle stall[0]=1; flush_cnt_o increments each flush cycle; both saturate at all-ones.
REQ-025 PIPE_CTRL_PERF_EN undefined: counters not built; stall_cnt_o and flush_cnt_o tied to 0; all other behaviour identical.

Verification
REQ-026 stallreq_id_i=1 and stallreq_ex_i=1 together in RUN -> stall=6'b001111 same cycle; both deasserted -> 6'b000000.
REQ-027 excepttype_i=32'h8, no mem stall -> detect cycle stall=6'b011111; next cycle flush=1, new_pc=32'h0000_0020, stall=0; cycle after flush=0.
REQ-028 excepttype_i=32'he, epc_i=32'h0000_1234 -> flush cycle new_pc=32'h0000_1234.
REQ-029 excepttype_i=32'h8 with stallreq_mem_i=1 for 3 cycles, excepttype_i changed to 32'he meanwhile -> no flush during stall; flush one cycle after mem req drops, new_pc=32'h0000_0020.
REQ-030 rst pulsed low during PEND -> flush never asserted, outputs zero, stall=0 during reset.
REQ-031 With PIPE_CTRL_PERF_EN: 5 stall cycles + 2 flushes -> stall_cnt_o=5 (plus detect/PEND cycles counted), flush_cnt_o=2; without macro both read 0.
